// File: rtl/uart_pkg.sv
// Framing constants and receiver state encodings shared by both ends of the serial link.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing an asynchronous input into the clk domain.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a falling-edge start, valid/ready output,
// frame-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 5208
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0]     HALF_LOAD = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]     FULL_LOAD = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev;
    logic                 fall;
    rx_state_t            state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [BIT_IDX_W-1:0] bit_idx, bit_next;
    logic                 byte_done;
    logic                 stop_low;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // rx_prev tracks rx_s in every state, so after BREAK or STOP an edge is only seen
    // once the line has actually been high in IDLE's view.
    assign fall = rx_prev & ~rx_s;
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shift_next = shift;
        bit_next   = bit_idx;
        byte_done  = 1'b0;
        stop_low   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall) begin
                    cnt_next   = HALF_LOAD;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (!rx_s) begin
                    cnt_next   = FULL_LOAD;
                    bit_next   = '0;
                    state_next = ST_DATA;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    shift_next = {rx_s, shift[DATA_BITS-1:1]};
                    cnt_next   = FULL_LOAD;
                    if (bit_idx == LAST_BIT) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (rx_s) begin
                    byte_done  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    stop_low   = 1'b1;
                    state_next = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A completed byte is taken only when the output slot is empty or being consumed
    // this cycle; otherwise it is dropped and flagged as an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev   <= 1'b1;
            cnt       <= '0;
            shift     <= '0;
            bit_idx   <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_prev   <= rx_s;
            cnt       <= cnt_next;
            shift     <= shift_next;
            bit_idx   <= bit_next;
            frame_err <= stop_low;
            overrun   <= byte_done & valid & ~ready;
            if (byte_done && (!valid || ready)) begin
                data  <= shift;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 5208; clocks per bit (9600 baud at 50 MHz); legal range 8..65535.
REQ-002 SHALL have port clk  input  1  system clock; the only clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high; 8N1, LSB first.
REQ-005 SHALL have port data  output  8  last received byte.
REQ-006 SHALL have port valid  output  1  data holds an unconsumed byte.
REQ-007 SHALL have port ready  input  1  consumer accepts data in any cycle where valid and ready are both high.
REQ-008 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a byte completes while valid is high and ready is low.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all logic SHALL use the synchronized value rx_s.
REQ-012 SHALL implement the FSM states IDLE, START, DATA, STOP and BREAK.
REQ-013 IDLE: a high-to-low transition of rx_s SHALL load the bit counter with CLK_PER_BIT/2-1 (integer division) and enter START.
REQ-014 START: at counter zero, rx_s low SHALL reload the counter with CLK_PER_BIT-1 and enter DATA; rx_s high SHALL be treated as a glitch and return the FSM to IDLE with no output.
REQ-015 DATA: at each counter zero, the FSM SHALL shift rx_s into bit 7 of the shift register (right shift) and reload the counter.
REQ-016 DATA: after the 8th sample, the FSM SHALL enter STOP.
REQ-017 STOP: at counter zero, rx_s high SHALL complete the byte and return the FSM to IDLE in the same cycle.
REQ-018 STOP: at counter zero, rx_s low SHALL pulse frame_err, discard the byte and enter BREAK.
REQ-019 BREAK: the FSM SHALL remain until rx_s is high, then go to IDLE; a falling edge SHALL NOT be detected in BREAK.
REQ-020 Byte completion with valid low, or with valid and ready both high, SHALL update data and set valid on the next cycle.
REQ-021 Byte completion with valid high and ready low SHALL pulse overrun, drop the new byte and leave data and valid unchanged.
REQ-022 valid SHALL clear the cycle after a handshake unless REQ-020 reloads it in the same cycle.
REQ-023 data SHALL remain stable while valid is high.
REQ-024 Latency SHALL be: valid rises at most 3 clk cycles after the stop-bit midpoint on rx (2 for synchronization, 1 for registering).
REQ-025 The bit counter SHALL be wide enough for CLK_PER_BIT-1; the counter SHALL NOT wrap.
REQ-026 A falling edge occurring in the same cycle as return to IDLE from STOP SHALL be detected, supporting back-to-back frames with no idle gap.

Reset
REQ-027 While rst is high, the FSM SHALL be in IDLE.
REQ-028 While rst is high, the synchronizer flops SHALL be 1 and the counter and shift register SHALL be 0.
REQ-029 While rst is high, data=8'h00, valid=0, busy=0, frame_err=0 and overrun=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame.
REQ-031 After reset, the next falling edge SHALL start a new frame.

Structure
REQ-032 FSM state encodings SHALL live in shared package uart_pkg, alongside the 8N1 constants (DATA_BITS=8).
REQ-033 uart_pkg SHALL be shared with the existing serial transmitter so that both ends agree on framing.
REQ-034 The 2-flop synchronizer SHALL be the single sub-module, named sync2.
REQ-035 All other logic SHALL be in uart_rx.

Verification (CLK_PER_BIT=16 unless noted)
REQ-036 Send 8'h46 ('F'), with ready held high -> data=8'h46 and a 1-cycle valid pulse; frame_err=0 and overrun=0.
REQ-037 Send "Fizz\r\n" back-to-back with no idle between frames, ready high -> 6 bytes 46 69 7A 7A 0D 0A delivered in order with no loss.
REQ-038 Drive rx low for 5 cycles, then high -> no valid, busy returns low, FSM back in IDLE.
REQ-039 Send 8'h55 with the stop bit low -> frame_err pulses once and valid stays 0; hold rx low 100 cycles, then send 8'h31 -> data=8'h31.
REQ-040 ready=0; send 8'h41 then 8'h42 -> data=8'h41, valid held, overrun pulses once; raise ready -> 8'h41 consumed and valid drops.
REQ-041 With CLK_PER_BIT=5208, send a fizzbuzz line "Buzz\r\n", asserting rst mid-frame on the 'B' -> 'B' is lost; after rst releases, the remaining characters of the following frames decode correctly.
